// File: rtl/alu_shift_seq.sv
// alu_shift_seq: iterative 16-bit shift/rotate unit with a start/busy/done handshake.
// Supports SLL, SRL, SRA and ROR, and reports z/v/n like the ALU shift ops.
// By default it shifts one bit per clock.
// Optional macro SHIFT_FAST_EN: while the remaining count is >= 4, shift by 4 per clock.
// Results are identical with or without the macro; only the latency changes.
module alu_shift_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       shift_op,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] alu_out,
    output logic             z,
    output logic             v,
    output logic             n
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   alu_out_q, alu_out_d;
    logic               z_q, z_d;
    logic [CNT_W-1:0]   amt;

    // Single-bit step. The fill bit depends on the operation:
    // SRA replicates the sign bit, and ROR wraps bit 0 around to the top.
    function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] w,
                                                   input logic [1:0]       op);
        logic [WIDTH-1:0] r;
        case (op)
            OP_SLL:  r = {w[WIDTH-2:0], 1'b0};
            OP_SRL:  r = {1'b0, w[WIDTH-1:1]};
            OP_SRA:  r = {w[WIDTH-1], w[WIDTH-1:1]};
            default: r = {w[0], w[WIDTH-1:1]};
        endcase
        return r;
    endfunction

    // Effective shift amount. Linear shifts saturate at 16 when any upper bit
    // of alu_b is set. Rotates only use the low four bits, since rotating by
    // 16 is the same as rotating by 0.
    always_comb begin
        amt = CNT_W'(alu_b[3:0]);
        if (shift_op != OP_ROR && alu_b[WIDTH-1:4] != '0) begin
            amt = CNT_W'(WIDTH);
        end
    end

    // State and datapath registers. Reset is synchronous and overrides an
    // in-flight request, so no done pulse follows a reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= 2'b00;
            work_q    <= '0;
            cnt_q     <= '0;
            alu_out_q <= '0;
            z_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            alu_out_q <= alu_out_d;
            z_q       <= z_d;
        end
    end

    // Next-state logic. The result and zero flag are captured on the same edge
    // that enters DONE, so they stay stable for the whole busy period.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        alu_out_d = alu_out_q;
        z_d       = z_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d   = shift_op;
                    work_d = alu_a;
                    cnt_d  = amt;
                    if (amt == '0) begin
                        state_d   = DONE;
                        alu_out_d = alu_a;
                        z_d       = (alu_a == '0);
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
`ifdef SHIFT_FAST_EN
                if (cnt_q >= CNT_W'(4)) begin
                    work_d = shift_one(shift_one(shift_one(shift_one(work_q, op_q), op_q), op_q), op_q);
                    cnt_d  = cnt_q - CNT_W'(4);
                end else begin
                    work_d = shift_one(work_q, op_q);
                    cnt_d  = cnt_q - CNT_W'(1);
                end
`else
                work_d = shift_one(work_q, op_q);
                cnt_d  = cnt_q - CNT_W'(1);
`endif
                if (cnt_d == '0) begin
                    state_d   = DONE;
                    alu_out_d = work_d;
                    z_d       = (work_d == '0);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs are decoded from the state. Shifts never overflow and
    // never report a sign, so v and n are constant zero.
    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    assign alu_out = alu_out_q;
    assign z       = z_q;
    assign v       = 1'b0;
    assign n       = 1'b0;

endmodule

// File: tb/tb_alu_shift_seq.sv
// tb_alu_shift_seq: scoreboard bench for alu_shift_seq.
// A reference model computes each expected result and latency when a request
// is driven. Scenario tasks pop the expectation when done appears and compare.
module tb_alu_shift_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  shift_op = 2'b00;
    logic [15:0] alu_a = 16'h0;
    logic [15:0] alu_b = 16'h0;
    logic        busy, done, z, v, n;
    logic [15:0] alu_out;

    typedef struct {
        logic [15:0] out;
        logic        z;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] held_out;

    alu_shift_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .shift_op (shift_op),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .busy     (busy),
        .done     (done),
        .alu_out  (alu_out),
        .z        (z),
        .v        (v),
        .n        (n)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Reference model: whole-word shifts plus the expected latency.
    function automatic void model(input logic [1:0] op, input logic [15:0] a,
                                  input logic [15:0] b, output logic [15:0] r,
                                  output int lat);
        int amt;
        logic [31:0] dbl;
        if (op == 2'b11) amt = int'(b[3:0]);
        else if (b[15:4] != 12'h0) amt = 16;
        else amt = int'(b[3:0]);
        case (op)
            2'b00: r = (amt >= 16) ? 16'h0 : (a << amt);
            2'b01: r = (amt >= 16) ? 16'h0 : (a >> amt);
            2'b10: r = 16'($signed(a) >>> amt);
            default: begin
                dbl = {a, a} >> amt;
                r = dbl[15:0];
            end
        endcase
        if (amt == 0) lat = 1;
`ifdef SHIFT_FAST_EN
        else lat = amt / 4 + amt % 4 + 1;
`else
        else lat = amt + 1;
`endif
    endfunction

    // Drive one accepted request, which takes one edge, and push its expectation.
    // Entered and left at a negedge; on return we are in cycle 1.
    task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        int lat;
        exp_t e;
        model(op, a, b, r, lat);
        e.out = r;
        e.z = (r == 16'h0);
        e.lat = lat;
        sb.push_back(e);
        held_out = alu_out;
        shift_op = op;
        alu_a = a;
        alu_b = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        shift_op = 2'($urandom);
        alu_a = 16'($urandom);
        alu_b = 16'($urandom);
    endtask

    // Wait, with a bound, for done. Reports the cycle in which done was seen and
    // whether alu_out moved before that cycle.
    task automatic wait_done(output int cyc, output bit to, output bit chg);
        cyc = 1;
        chg = 1'b0;
        while (done !== 1'b1 && cyc < 40) begin
            if (alu_out !== held_out) chg = 1'b1;
            @(negedge clk);
            cyc++;
        end
        to = (done !== 1'b1);
    endtask

    // Reset state of every output.
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done got %b want 0", done); end
        n_checks++; if (alu_out !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_out got %h want 0000", alu_out); end
        n_checks++; if (z !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_z got %b want 0", z); end
        n_checks++; if (v !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_v got %b want 0", v); end
        n_checks++; if (n !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_n got %b want 0", n); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Table-driven requests covering the listed cases and boundaries.
    task automatic test_directed();
        logic [1:0]  ops[8] = '{2'b10, 2'b01, 2'b10, 2'b10, 2'b00, 2'b11, 2'b00, 2'b11};
        logic [15:0] as[8]  = '{16'hAA00, 16'h00FF, 16'hFFFF, 16'h8000, 16'h0001, 16'h0001, 16'hFFFF, 16'hBEEF};
        logic [15:0] bs[8]  = '{16'h0004, 16'h0008, 16'h0001, 16'h0100, 16'h0000, 16'h0011, 16'h0010, 16'h0000};
        int cyc;
        bit to, chg;
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_done(cyc, to, chg);
            n_checks++;
            if (to) begin n_fail++; $display("[TB] FAIL dir%0d_timeout got no done want done", i); end
            if (sb.size() == 0) begin
                n_fail++; $display("[TB] FAIL dir%0d_scoreboard got empty want entry", i);
            end else begin
                e = sb.pop_front();
                n_checks++; if (cyc != e.lat) begin n_fail++; $display("[TB] FAIL dir%0d_latency got %0d want %0d", i, cyc, e.lat); end
                n_checks++; if (alu_out !== e.out) begin n_fail++; $display("[TB] FAIL dir%0d_out got %h want %h", i, alu_out, e.out); end
                n_checks++; if (z !== e.z) begin n_fail++; $display("[TB] FAIL dir%0d_z got %b want %b", i, z, e.z); end
                n_checks++; if ({v, n} !== 2'b00) begin n_fail++; $display("[TB] FAIL dir%0d_vn got %b want 00", i, {v, n}); end
                n_checks++; if (chg) begin n_fail++; $display("[TB] FAIL dir%0d_stable got changed want held", i); end
            end
            @(negedge clk);
            n_checks++; if ({busy, done} !== 2'b00) begin n_fail++; $display("[TB] FAIL dir%0d_after got busy/done %b want 00", i, {busy, done}); end
        end
    endtask

    // A start while busy is ignored; a start in the cycle after done is accepted.
    task automatic test_busy_ignore();
        int cyc;
        bit to, chg;
        exp_t e;
        issue(2'b00, 16'h1234, 16'd15);
        @(negedge clk);
        @(negedge clk);
        shift_op = 2'b01; alu_a = 16'hFFFF; alu_b = 16'h0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL ign_busy got %b want 1", busy); end
        wait_done(cyc, to, chg);
        cyc += 3;
        e = sb.pop_front();
        n_checks++; if (to || cyc != e.lat) begin n_fail++; $display("[TB] FAIL ign_latency got %0d want %0d", cyc, e.lat); end
        n_checks++; if (alu_out !== 16'h0000) begin n_fail++; $display("[TB] FAIL ign_out got %h want 0000", alu_out); end
        n_checks++; if (z !== 1'b1) begin n_fail++; $display("[TB] FAIL ign_z got %b want 1", z); end
        n_checks++; if (chg) begin n_fail++; $display("[TB] FAIL ign_stable got changed want held", ); end
        @(negedge clk);
        issue(2'b01, 16'h8000, 16'd3);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL accept_after_done got busy %b want 1", busy); end
        wait_done(cyc, to, chg);
        e = sb.pop_front();
        n_checks++; if (to || cyc != e.lat || alu_out !== e.out) begin n_fail++; $display("[TB] FAIL accept_result got %h@%0d want %h@%0d", alu_out, cyc, e.out, e.lat); end
        @(negedge clk);
    endtask

    // Reset in the middle of a request discards it, and a later request still works.
    task automatic test_reset_abort();
        int cyc;
        bit to, chg, seen;
        exp_t e;
        issue(2'b10, 16'h8000, 16'd10);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_done got %b want 0", done); end
        n_checks++; if (alu_out !== 16'h0) begin n_fail++; $display("[TB] FAIL abort_out got %h want 0000", alu_out); end
        n_checks++; if (z !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_z got %b want 0", z); end
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        n_checks++; if (seen) begin n_fail++; $display("[TB] FAIL abort_no_done got activity want none"); end
        issue(2'b01, 16'h0010, 16'd4);
        wait_done(cyc, to, chg);
        e = sb.pop_front();
        n_checks++; if (to || cyc != e.lat) begin n_fail++; $display("[TB] FAIL post_reset_latency got %0d want %0d", cyc, e.lat); end
        n_checks++; if (alu_out !== 16'h0001) begin n_fail++; $display("[TB] FAIL post_reset_out got %h want 0001", alu_out); end
        @(negedge clk);
    endtask

    // Random requests, each started in the cycle right after the previous done.
    task automatic test_back_to_back();
        int cyc;
        bit to, chg;
        exp_t e;
        logic [15:0] b;
        for (int i = 0; i < 12; i++) begin
            b = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16));
            issue(2'($urandom), 16'($urandom), b);
            wait_done(cyc, to, chg);
            e = sb.pop_front();
            n_checks++; if (to || cyc != e.lat) begin n_fail++; $display("[TB] FAIL b2b%0d_latency got %0d want %0d", i, cyc, e.lat); end
            n_checks++; if (alu_out !== e.out || z !== e.z) begin n_fail++; $display("[TB] FAIL b2b%0d_result got %h/%b want %h/%b", i, alu_out, z, e.out, e.z); end
            @(negedge clk);
        end
    endtask

    // Run the scenarios in sequence, then print the summary line.
    initial begin
        @(negedge clk);
        test_reset();
        test_directed();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_shift_seq.md
Name: alu_shift_seq

Overview:
- Multi-cycle sequential shift/rotate unit for the 16-bit datapath.
- Takes shift requests through a start/busy/done handshake and shifts one bit per clock.
- Returns the result with the same z/v/n flag conventions as the combinational ALU shift ops.
- Sits beside the ALU as the iterative shift path, for targets where a barrel shifter is too costly.

Parameters:
- WIDTH, 16, datapath width in bits; must be 16 in this design.
- CNT_W, 5, shift-count register width; must hold the value 16.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- start  input  1  request strobe; accepted only while busy=0.
- shift_op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right).
- alu_a  input  16  operand to shift; sampled on the accepting edge.
- alu_b  input  16  shift amount; sampled on the accepting edge.
- busy  output  1  high while a request is in progress (state != IDLE).
- done  output  1  one-cycle pulse when alu_out and the flags are valid and updated.
- alu_out  output  16  registered result; holds its value until the next done.
- z  output  1  zero flag: alu_out == 0.
- v  output  1  overflow flag; always 0 for shift ops.
- n  output  1  sign flag; always 0 for shift ops.

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE; busy, done, z, v, n = 0; alu_out=0; internal work and count registers = 0. Reset has priority over everything, including mid-operation; an in-flight request is discarded with no done pulse.
- States: IDLE, SHIFT, DONE.
- Effective amount amt:
  - SLL/SRL/SRA: amt = 16 if alu_b[15:4] != 0, else alu_b[3:0].
  - ROR: amt = alu_b[3:0] only.
- IDLE, start=1 on an edge: latch op, work=alu_a, cnt=amt. Next state is SHIFT if amt != 0, else DONE.
- IDLE, start=0: remain in IDLE.
- SHIFT, each edge: shift work by 1 and decrement cnt.
  - SLL inserts 0 at bit 0.
  - SRL inserts 0 at bit 15.
  - SRA inserts the old work[15] at bit 15.
  - ROR moves bit 0 to bit 15.
  - When cnt transitions 1 -> 0, next state is DONE.
- Entry into DONE (same edge): alu_out=final work; z=(final work==0); v=0; n=0.
- DONE: done=1 for exactly this one cycle; next state is IDLE unconditionally.
- busy=1 in SHIFT and DONE. A start seen while busy is ignored, not queued. A start in the cycle after done (state back in IDLE) is accepted.
- Latency, counting the accepting edge as edge 1: done is high in cycle 1 for amt=0, and in cycle amt+1 for amt>=1. Maximum is cycle 17.
- Boundary results:
  - SLL/SRL with amt=16 yield 0.
  - SRA with amt=16 yields 0xFFFF if alu_a[15]=1, else 0x0000.
  - ROR by 0 returns alu_a unchanged.
- alu_out, z, v, n stay stable while busy; they change only on entry to DONE.
- Operand inputs may change freely after the accepting edge without affecting the result.

Optional Feature:
- Macro: SHIFT_FAST_EN.
- Defined: in SHIFT, if cnt>=4, shift by 4 in one cycle (same fill rules as the single-bit step, applied four times) and cnt-=4; otherwise shift by 1.
  - Latency for amt>=1: done in cycle floor(amt/4)+(amt mod 4)+1.
  - amt=0: done in cycle 1, unchanged.
  - Results and flags are identical to the non-fast build.
- Undefined: strictly one bit per cycle, as specified above.

Test Plan:
- SRA, alu_a=0xAA00, alu_b=4 -> done in cycle 5 (cycle 2 with SHIFT_FAST_EN); alu_out=0xFAA0, z=0, n=0, v=0.
- SRL, alu_a=0x00FF, alu_b=8 -> done in cycle 9 (cycle 3 with SHIFT_FAST_EN); alu_out=0x0000, z=1, n=0, v=0.
- SRA, alu_a=0xFFFF, alu_b=1 -> done in cycle 2; alu_out=0xFFFF, z=0, n=0. Then SRA, alu_a=0x8000, alu_b=0x0100 -> amt=16; done in cycle 17; alu_out=0xFFFF.
- SLL, alu_a=0x0001, alu_b=0 -> done in cycle 1; alu_out=0x0001. Then ROR, alu_a=0x0001, alu_b=0x0011 -> done in cycle 2; alu_out=0x8000.
- Start SLL, alu_a=0x1234, alu_b=15; in cycle 3 pulse start with SRL, alu_a=0xFFFF, alu_b=1 -> second request ignored; done only in cycle 16 with alu_out=0x0000, z=1. A start in cycle 17 is accepted.
- Start SRA, alu_a=0x8000, alu_b=10; assert rst_n=0 in cycle 4 -> next cycle busy=0, done=0, alu_out=0, z=0, and no done pulse follows. After release, a new SRL, alu_a=0x0010, alu_b=4 gives alu_out=0x0001 in cycle 5.
